// File: rtl/dram_responder.sv
// dram_responder: word-addressed 1R1W memory with fixed read latency, sticky range error and saturating traffic counters.
// Array contents are never reset, so preloaded data survives srstn.
module dram_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int MEM_DEPTH  = 262144,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  dram_en_rd,
  input  logic [ADDR_WIDTH-1:0] addr_rd,
  input  logic                  dram_en_wr,
  input  logic [ADDR_WIDTH-1:0] addr_wr,
  input  logic [DATA_WIDTH-1:0] data_wr,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  dram_valid,
  output logic                  addr_err,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] dat [RD_LATENCY];
  logic [RD_LATENCY-1:0] vld;
  logic                  rd_ok, wr_ok, wr_hit;
  logic [DATA_WIDTH-1:0] rd_word;
  always_comb begin
    rd_ok   = {1'b0, addr_rd} < DEPTH;
    wr_ok   = {1'b0, addr_wr} < DEPTH;
    wr_hit  = dram_en_wr && wr_ok;
    // write-first bypass so a same-cycle read sees the incoming word
    rd_word = !rd_ok ? '0 : (wr_hit && addr_wr == addr_rd) ? data_wr : mem[addr_rd[IW-1:0]];
  end
  always_ff @(posedge clk)
    if (srstn && wr_hit) mem[addr_wr[IW-1:0]] <= data_wr;
  // each stage loads only behind a valid word, so the last stage holds between reads
  always_ff @(posedge clk) begin
    if (!srstn) begin
      vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
    end else begin
      vld <= (vld << 1) | RD_LATENCY'(dram_en_rd);
      if (dram_en_rd) dat[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) if (vld[i-1]) dat[i] <= dat[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (!srstn) begin
      addr_err <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if ((dram_en_rd && !rd_ok) || (dram_en_wr && !wr_ok)) addr_err <= 1'b1;
      if (dram_en_rd && !(&rd_count)) rd_count <= rd_count + 1'b1;
      if (dram_en_wr && !(&wr_count)) wr_count <= wr_count + 1'b1;
    end
  end
  assign data_rd    = dat[RD_LATENCY-1];
  assign dram_valid = vld[RD_LATENCY-1];
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: three responder configurations driven by directed and random traffic, checked against a queue-based reference.
module tb_dram_responder;
  localparam int LAT[3]  = '{1, 3, 2};
  localparam int DEP[3]  = '{262144, 1024, 1024};
  localparam int CMAX[3] = '{65535, 15, 65535};
  typedef struct { int inst; int due; logic [31:0] d; } rd_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        srstn[3], en_rd[3], en_wr[3], dv[3], aerr[3];
  logic [17:0] ard[3], awr[3];
  logic [31:0] dw[3], drd[3];
  logic [15:0] rc0, wc0, rc2, wc2;
  logic [3:0]  rc1, wc1;
  int ntest = 0, nfail = 0, cyc = 0;
  rd_t pend[$];
  logic [31:0] mmem[int];
  logic [31:0] last[3];
  logic        merr[3];
  int          mrc[3], mwc[3];

  dram_responder u0 (.clk(clk), .srstn(srstn[0]), .dram_en_rd(en_rd[0]), .addr_rd(ard[0]),
    .dram_en_wr(en_wr[0]), .addr_wr(awr[0]), .data_wr(dw[0]), .data_rd(drd[0]),
    .dram_valid(dv[0]), .addr_err(aerr[0]), .rd_count(rc0), .wr_count(wc0));
  dram_responder #(.MEM_DEPTH(1024), .RD_LATENCY(3), .CNT_WIDTH(4)) u1 (.clk(clk), .srstn(srstn[1]),
    .dram_en_rd(en_rd[1]), .addr_rd(ard[1]), .dram_en_wr(en_wr[1]), .addr_wr(awr[1]), .data_wr(dw[1]),
    .data_rd(drd[1]), .dram_valid(dv[1]), .addr_err(aerr[1]), .rd_count(rc1), .wr_count(wc1));
  dram_responder #(.MEM_DEPTH(1024), .RD_LATENCY(2)) u2 (.clk(clk), .srstn(srstn[2]),
    .dram_en_rd(en_rd[2]), .addr_rd(ard[2]), .dram_en_wr(en_wr[2]), .addr_wr(awr[2]), .data_wr(dw[2]),
    .data_rd(drd[2]), .dram_valid(dv[2]), .addr_err(aerr[2]), .rd_count(rc2), .wr_count(wc2));

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    ntest++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  task automatic rd(int i, int a);
    en_rd[i] = 1'b1;
    ard[i]   = 18'(a);
  endtask

  task automatic wr(int i, int a, logic [31:0] d);
    en_wr[i] = 1'b1;
    awr[i]   = 18'(a);
    dw[i]    = d;
  endtask

  // reference: reads become scheduled deliveries at issue cycle + latency
  task automatic model_pre();
    for (int i = 0; i < 3; i++) begin
      if (!srstn[i]) begin
        for (int j = pend.size() - 1; j >= 0; j--) if (pend[j].inst == i) pend.delete(j);
        merr[i] = 1'b0; mrc[i] = 0; mwc[i] = 0; last[i] = '0;
      end else begin
        if (en_rd[i]) begin
          int a = int'(ard[i]);
          int k = i * (1 << 20) + a;
          logic [31:0] v;
          v = a >= DEP[i] ? 32'd0 : (en_wr[i] && awr[i] == ard[i]) ? dw[i] : (mmem.exists(k) ? mmem[k] : 32'd0);
          pend.push_back('{i, cyc + LAT[i], v});
          if (a >= DEP[i]) merr[i] = 1'b1;
          if (mrc[i] < CMAX[i]) mrc[i]++;
        end
        if (en_wr[i]) begin
          int a = int'(awr[i]);
          if (a < DEP[i]) mmem[i * (1 << 20) + a] = dw[i];
          else merr[i] = 1'b1;
          if (mwc[i] < CMAX[i]) mwc[i]++;
        end
      end
    end
  endtask

  task automatic model_post();
    for (int i = 0; i < 3; i++) begin
      logic ev = 1'b0;
      logic [15:0] orc, owc;
      for (int j = pend.size() - 1; j >= 0; j--)
        if (pend[j].inst == i && pend[j].due == cyc) begin
          ev = 1'b1;
          last[i] = pend[j].d;
          pend.delete(j);
        end
      orc = i == 0 ? rc0 : i == 1 ? {12'd0, rc1} : rc2;
      owc = i == 0 ? wc0 : i == 1 ? {12'd0, wc1} : wc2;
      chk($sformatf("dram_valid%0d", i), {31'd0, dv[i]}, {31'd0, ev});
      chk($sformatf("data_rd%0d", i), drd[i], last[i]);
      chk($sformatf("addr_err%0d", i), {31'd0, aerr[i]}, {31'd0, merr[i]});
      chk($sformatf("rd_count%0d", i), {16'd0, orc}, 32'(mrc[i]));
      chk($sformatf("wr_count%0d", i), {16'd0, owc}, 32'(mwc[i]));
    end
  endtask

  task automatic step();
    model_pre();
    @(posedge clk);
    #1;
    cyc++;
    model_post();
    for (int i = 0; i < 3; i++) begin
      en_rd[i] = 1'b0;
      en_wr[i] = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      srstn[i] = 1'b0; en_rd[i] = 1'b0; en_wr[i] = 1'b0;
      ard[i] = '0; awr[i] = '0; dw[i] = '0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      last[i] = '0; merr[i] = 1'b0; mrc[i] = 0; mwc[i] = 0;
    end
    step();
    step();
    for (int i = 0; i < 3; i++) srstn[i] = 1'b1;
    // burst of five reads on the latency-1 instance
    for (int a = 0; a < 5; a++) begin wr(0, 65536 + a, 32'(a + 1)); step(); end
    for (int a = 0; a < 5; a++) begin rd(0, 65536 + a); step(); chk("burst_data", drd[0], 32'(a + 1)); end
    step();
    chk("burst_hold", drd[0], 32'd5);
    chk("burst_rdcnt", {16'd0, rc0}, 32'd5);
    // same-cycle write and read: write-first
    wr(0, 131072, 32'hDEADBEEF); rd(0, 131072); step();
    chk("wr_first", drd[0], 32'hDEADBEEF);
    // read-modify-write at latency 1
    wr(0, 131072, 32'd0); step();
    for (int n = 0; n < 4; n++) begin
      rd(0, 131072); step();
      wr(0, 131072, drd[0] + 32'd1); step();
    end
    rd(0, 131072); step();
    chk("rmw_final", drd[0], 32'd4);
    // latency 3: in-flight data unaffected by later write
    wr(1, 100, 32'd7); step();
    rd(1, 100); step();
    wr(1, 100, 32'd9); step();
    rd(1, 100); step();
    chk("lat3_first", drd[1], 32'd7);
    step();
    chk("lat3_hold", drd[1], 32'd7);
    step();
    chk("lat3_second", drd[1], 32'd9);
    // out-of-range write and read
    wr(1, 1024, 32'h1234_5678); rd(1, 2000); step();
    step(); step();
    chk("oor_valid", {31'd0, dv[1]}, 32'd1);
    chk("oor_data", drd[1], 32'd0);
    rd(1, 0); step();
    for (int n = 0; n < 4; n++) step();
    chk("oor_err_held", {31'd0, aerr[1]}, 32'd1);
    for (int n = 0; n < 20; n++) begin rd(1, 100); step(); end
    for (int n = 0; n < 3; n++) step();
    chk("rdcnt_sat", {28'd0, rc1}, 32'd15);
    // latency 2: reset drops in-flight reads, memory survives
    wr(2, 5, 32'h55); step();
    rd(2, 5); step();
    rd(2, 5); step();
    srstn[2] = 1'b0; rd(2, 5); wr(2, 6, 32'h66); step();
    srstn[2] = 1'b1;
    for (int n = 0; n < 4; n++) begin step(); chk("rst_no_valid", {31'd0, dv[2]}, 32'd0); end
    chk("rst_rdcnt", {16'd0, rc2}, 32'd0);
    rd(2, 5); step(); step();
    chk("rst_mem_kept", drd[2], 32'h55);
    // random traffic on all instances over a small initialised window
    for (int a = 0; a < 8; a++) begin
      for (int i = 0; i < 3; i++) wr(i, a, $urandom);
      step();
    end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        srstn[i] = ($urandom % 50) != 0;
        if ($urandom % 2 == 1) rd(i, (i > 0 && $urandom % 8 == 0) ? 1024 + int'($urandom % 1024) : int'($urandom % 8));
        if ($urandom % 2 == 1) wr(i, (i > 0 && $urandom % 8 == 0) ? 1024 + int'($urandom % 1024) : int'($urandom % 8), $urandom);
      end
      step();
    end
    for (int i = 0; i < 3; i++) srstn[i] = 1'b1;
    for (int n = 0; n < 5; n++) step();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
